// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit
// ----------------------------------------------------------------------------
// Multi-cycle RV32IM control FSM. It sequences each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives every enable and mux
// select of the shared-memory datapath. Memory accesses and the mul/div unit
// are waited on through handshakes. A bounded wait on the mul/div unit traps
// if the result never arrives.
//
// Parameters
//   M_EXT       1 enables the M extension (funct7=0000001 R-type)
//   MD_TIMEOUT  max MDWAIT cycles before trapping (2..1023)
//
// Ports
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   op_i, funct3_i, funct7_i       fields from the instruction register
//   zero_i, lt_i, ltu_i            rs1-rs2 compare flags (current cycle)
//   mem_ready_i                    memory access completes this cycle
//   md_done_i                      mul/div result valid pulse
//   pcWrite_o, adrSrc_o, memWrite_o, irWrite_o, resultSrc_o,
//   aluSrcA_o, aluSrcB_o, aluControl_o, immSrc_o, regWrite_o
//                                  datapath enables / mux selects
//   md_start_o, md_op_o            mul/div start pulse and operation
//   instr_done_o                   one-cycle pulse per retired instruction
//   illegal_o                      sticky trap flag
// ============================================================================
module multicycle_control_unit #(
    parameter bit M_EXT      = 1'b1,
    parameter int MD_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    input  logic       mem_ready_i,
    input  logic       md_done_i,
    output logic       pcWrite_o,
    output logic       adrSrc_o,
    output logic       memWrite_o,
    output logic       irWrite_o,
    output logic [1:0] resultSrc_o,
    output logic [1:0] aluSrcA_o,
    output logic [1:0] aluSrcB_o,
    output logic [4:0] aluControl_o,
    output logic [2:0] immSrc_o,
    output logic       regWrite_o,
    output logic       md_start_o,
    output logic [2:0] md_op_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    localparam int CNT_W = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00010;
    localparam logic [4:0] ALU_SLT  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_MDWAIT, S_BRANCH, S_JAL, S_JALR,
        S_LUI, S_AUIPC, S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic f7_zero, f7_alt, f7_m;
    logic r_alu_ok, r_md_ok, i_ok, br_ok, taken, md_last, is_link;

    assign f7_zero  = (funct7_i == 7'b0000000);
    assign f7_alt   = (funct7_i == 7'b0100000);
    assign f7_m     = (funct7_i == 7'b0000001);
    assign r_alu_ok = f7_zero || (f7_alt && (funct3_i == 3'b000 || funct3_i == 3'b101));
    assign r_md_ok  = f7_m && M_EXT;
    assign br_ok    = (funct3_i != 3'b010) && (funct3_i != 3'b011);
    assign md_last  = (cnt_q == CNT_LAST);
    // JAL/JALR reuse ALUWB but must write OldPC+4 rather than ALUOut
    assign is_link  = (op_i == OP_JAL) || (op_i == OP_JALR);

    always_comb begin
        case (funct3_i)
            3'b001:  i_ok = f7_zero;
            3'b101:  i_ok = f7_zero || f7_alt;
            default: i_ok = 1'b1;
        endcase
    end

    always_comb begin
        case (funct3_i)
            3'b000:  taken = zero_i;
            3'b001:  taken = !zero_i;
            3'b100:  taken = lt_i;
            3'b101:  taken = !lt_i;
            3'b110:  taken = ltu_i;
            3'b111:  taken = !ltu_i;
            default: taken = 1'b0;
        endcase
    end

    // alt selects SUB/SRA; callers decide when funct7 may carry that meaning
    function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op_i == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
            S_EXEC_R: begin
                if (r_md_ok)       state_d = S_MDWAIT;
                else if (r_alu_ok) state_d = S_ALUWB;
                else               state_d = S_TRAP;
            end
            S_EXEC_I: state_d = i_ok ? S_ALUWB : S_TRAP;
            S_ALUWB:  state_d = S_FETCH;
            // md_done wins over the timeout on the last allowed cycle
            S_MDWAIT: begin
                if (md_done_i)    state_d = S_FETCH;
                else if (md_last) state_d = S_TRAP;
            end
            S_BRANCH: state_d = br_ok ? S_FETCH : S_TRAP;
            S_JAL:    state_d = S_ALUWB;
            S_JALR:   state_d = (funct3_i == 3'b000) ? S_ALUWB : S_TRAP;
            S_LUI:    state_d = S_ALUWB;
            S_AUIPC:  state_d = S_ALUWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // ------------------------------------------------------------------
    // State, MDWAIT cycle counter (zero on the entry cycle), sticky trap
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == S_MDWAIT) ? cnt_q + CNT_W'(1) : '0;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state + fields; strobes qualified by
    // mem_ready / compare flags / md_done where the handshake requires it
    // ------------------------------------------------------------------
    always_comb begin
        pcWrite_o    = 1'b0;
        adrSrc_o     = 1'b0;
        memWrite_o   = 1'b0;
        irWrite_o    = 1'b0;
        resultSrc_o  = 2'b00;
        aluSrcA_o    = 2'b00;
        aluSrcB_o    = 2'b00;
        aluControl_o = ALU_ADD;
        immSrc_o     = 3'b000;
        regWrite_o   = 1'b0;
        md_start_o   = 1'b0;
        md_op_o      = 3'b000;
        instr_done_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                aluSrcB_o   = 2'b10;
                resultSrc_o = 2'b10;
                irWrite_o   = mem_ready_i;
                pcWrite_o   = mem_ready_i;
            end
            S_DECODE: begin
                // OldPC + imm_B lands in ALUOut as the branch target
                aluSrcA_o = 2'b01;
                aluSrcB_o = 2'b01;
                immSrc_o  = 3'b010;
            end
            S_MEMADR: begin
                aluSrcA_o = 2'b10;
                aluSrcB_o = 2'b01;
                immSrc_o  = (op_i == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMRD: adrSrc_o = 1'b1;
            S_MEMWB: begin
                resultSrc_o  = 2'b01;
                regWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWR: begin
                adrSrc_o     = 1'b1;
                memWrite_o   = mem_ready_i;
                instr_done_o = mem_ready_i;
            end
            S_EXEC_R: begin
                aluSrcA_o    = 2'b10;
                aluControl_o = alu_op(funct3_i, f7_alt);
            end
            S_EXEC_I: begin
                aluSrcA_o    = 2'b10;
                aluSrcB_o    = 2'b01;
                // funct7 bits are immediate bits except for SRAI
                aluControl_o = alu_op(funct3_i, f7_alt && (funct3_i == 3'b101));
            end
            S_ALUWB: begin
                regWrite_o   = 1'b1;
                instr_done_o = 1'b1;
                if (is_link) begin
                    aluSrcA_o   = 2'b01;
                    aluSrcB_o   = 2'b10;
                    resultSrc_o = 2'b10;
                end
            end
            S_MDWAIT: begin
                md_op_o    = funct3_i;
                md_start_o = (cnt_q == '0);
                if (md_done_i) begin
                    resultSrc_o  = 2'b11;
                    regWrite_o   = 1'b1;
                    instr_done_o = 1'b1;
                end
            end
            S_BRANCH: begin
                aluSrcA_o    = 2'b10;
                aluControl_o = ALU_SUB;
                pcWrite_o    = br_ok && taken;
                instr_done_o = br_ok;
            end
            S_JAL: begin
                aluSrcA_o   = 2'b01;
                aluSrcB_o   = 2'b01;
                immSrc_o    = 3'b100;
                resultSrc_o = 2'b10;
                pcWrite_o   = 1'b1;
            end
            S_JALR: begin
                if (funct3_i == 3'b000) begin
                    aluSrcA_o   = 2'b10;
                    aluSrcB_o   = 2'b01;
                    resultSrc_o = 2'b10;
                    pcWrite_o   = 1'b1;
                end
            end
            S_LUI: begin
                aluSrcA_o = 2'b11;
                aluSrcB_o = 2'b01;
                immSrc_o  = 3'b011;
            end
            S_AUIPC: begin
                aluSrcA_o = 2'b01;
                aluSrcB_o = 2'b01;
                immSrc_o  = 3'b011;
            end
            default: ;
        endcase
    end

    assign illegal_o = illegal_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the RV32IM core. It succeeds the single-cycle combinational decoder. It sequences each instruction over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It adds wait-state handshakes to instruction/data memory and to a variable-latency multiply/divide unit, and provides full branch-condition support. It sits between the instruction register and the shared-memory multi-cycle datapath, and drives every datapath enable and mux select.

## Interface
- M_EXT, 1: 1 enables the M extension; 0 makes funct7=0000001 R-type instructions illegal.
- MD_TIMEOUT, 64: maximum cycles to wait for md_done before trapping; range 2..1023.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25], full field.
- zero / lt / ltu  in  1 each  ALU flags from the current-cycle rs1−rs2 compare.
- mem_ready  in  1  memory access completes this cycle.
- md_done  in  1  mul/div result valid (one-cycle pulse).
- pcWrite  out  1  PC register load.
- adrSrc  out  1  memory address: 0=PC, 1=Result.
- memWrite  out  1  data store strobe.
- irWrite  out  1  instruction and OldPC register load.
- resultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=md_result.
- aluSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
- aluSrcB  out  2  00=rs2, 01=imm, 10=const 4.
- aluControl  out  5  ALU operation code.
- immSrc  out  3  000=I, 001=S, 010=B, 011=U, 100=J.
- regWrite  out  1  register file write.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_op  out  3  funct3 forwarded to the mul/div unit.
- instr_done  out  1  one-cycle pulse on each retired instruction.
- illegal  out  1  sticky trap flag.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, MDWAIT, BRANCH, JAL, JALR, LUI, AUIPC, TRAP. The state register is binary-encoded.
- All outputs are Moore outputs, decoded from the state plus op/funct fields. Exceptions: the mem_ready/flag-qualified strobes listed below.
- Unlisted outputs are 0 in every state.
- RESET: all outputs 0; next state FETCH.
- FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, ADD, resultSrc=10. irWrite and pcWrite are asserted only when mem_ready=1, then the FSM moves to DECODE. Otherwise it holds.
- DECODE: aluSrcA=01, aluSrcB=01, immSrc=010, ADD. This precomputes the branch target into ALUOut. Dispatch by op:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - other → TRAP
- MEMADR: aluSrcA=10, aluSrcB=01, ADD; immSrc=000 for loads, 001 for stores. Loads go to MEMRD, stores to MEMWR.
- MEMRD: adrSrc=1, resultSrc=00. On mem_ready the FSM moves to MEMWB.
- MEMWB: resultSrc=01, regWrite=1, instr_done=1; next state FETCH.
- MEMWR: adrSrc=1, resultSrc=00. memWrite is asserted only when mem_ready=1; on that cycle instr_done=1 and the next state is FETCH.
- EXEC_R: aluSrcA=10, aluSrcB=00.
  - funct7=0000000: next state ALUWB.
  - funct7=0100000 with funct3 000 or 101: next state ALUWB.
  - funct7=0000001 and M_EXT=1: next state MDWAIT.
  - Anything else: TRAP.
- EXEC_I: aluSrcA=10, aluSrcB=01, immSrc=000; next state ALUWB.
  - funct3=001 requires funct7=0000000, else TRAP.
  - funct3=101 requires funct7 0000000 or 0100000, else TRAP.
- ALU codes:
  - 00000 ADD
  - 00001 SUB
  - 00010 SLL
  - 00011 SLT
  - 00100 AND
  - 00101 OR
  - 00110 XOR
  - 00111 SRL
  - 01000 SRA
  - 01001 SLTU
- ALU mapping: ADDI never uses SUB. In R-type, funct7=0100000 selects SUB for funct3=000 and SRA for funct3=101.
- ALUWB: resultSrc=00, regWrite=1, instr_done=1; next state FETCH.
- MDWAIT:
  - md_op=funct3 throughout.
  - md_start=1 on the entry cycle only.
  - An internal counter clears on entry and increments each cycle.
  - On md_done: resultSrc=11, regWrite=1, instr_done=1, next state FETCH.
  - If the counter reaches MD_TIMEOUT−1 without md_done: TRAP.
- BRANCH: aluSrcA=10, aluSrcB=00, SUB, resultSrc=00. pcWrite = taken, where taken by funct3 is:
  - 000 zero
  - 001 !zero
  - 100 lt
  - 101 !lt
  - 110 ltu
  - 111 !ltu
  - 010/011 → TRAP, no pcWrite.
  - Otherwise: instr_done=1, next state FETCH.
- JAL: aluSrcA=01, aluSrcB=01, immSrc=100, ADD, resultSrc=10, pcWrite=1; next state ALUWB, which must write OldPC+4.
  - Implementation detail: JAL computes OldPC+imm_J as ALUResult and loads the PC. The ALUOut register is overwritten with OldPC+4 by a second ALU pass in ALUWB: aluSrcA=01, aluSrcB=10, resultSrc=10 for the JAL/JALR path.
- JALR:
  - funct3≠000 → TRAP.
  - Otherwise: aluSrcA=10, aluSrcB=01, immSrc=000, ADD, resultSrc=10, pcWrite=1; next state ALUWB, using the same OldPC+4 writeback path as JAL.
- LUI: aluSrcA=11, aluSrcB=01, immSrc=011; next state ALUWB.
- AUIPC: aluSrcA=01, aluSrcB=01, immSrc=011; next state ALUWB.
- TRAP: illegal=1, all strobes 0. The FSM stays in TRAP until reset.

## Timing
- rst_n low at an edge: state←RESET, counter←0, illegal←0. This applies mid-instruction too, including in MDWAIT or while awaiting mem_ready. No partial write is allowed after the reset edge.
- Minimum latency, with mem_ready tied to 1:
  - branch: 3 cycles
  - ALU/LUI/AUIPC: 4
  - JAL/JALR: 4
  - store: 4
  - load: 5
  - mul/div: 4 + (md_done latency)
- Each mem_ready-low cycle adds one cycle in FETCH/MEMRD/MEMWR.
- md_done arriving in the md_start cycle is accepted.
- md_done outside MDWAIT is ignored.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-MDWAIT → next cycle all outputs 0, state RESET, then FETCH.
- ADD x (op 0110011, f3 000, f7 0000000), mem_ready=1 → irWrite in cycle 1, aluControl 00000 in cycle 3, regWrite+instr_done in cycle 4; SUB (f7 0100000) gives 00001.
- Load with mem_ready low for 2 cycles in MEMRD → regWrite occurs at cycle 7, exactly once.
- BLT with lt=1 → pcWrite=1 in BRANCH; lt=0 → pcWrite=0; funct3=010 → illegal=1 and held.
- DIV (f7 0000001, f3 100), md_done after 5 cycles → md_start pulse once, md_op=100, resultSrc=11 with regWrite. With M_EXT=0, the same instruction → TRAP.
- MDWAIT with no md_done, MD_TIMEOUT=8 → TRAP entered after 8 MDWAIT cycles; regWrite never asserted.
